nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs WIDTH-bit additions by time-multiplexing one external 4-bit ripple-carry adder slice (A, B, Cin in; 5-bit Sum out) nibble by nibble, LSB first, and chains the carry between cycles. It sits between a valid/ready operand source and a valid/ready result sink. It owns the adder's inputs exclusively. It gives wide-operand addition at the cost of WIDTH/4 cycles per operation, with no extra adder hardware.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4 nibble steps.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  controller can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in to nibble 0
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_sum  output  WIDTH+1  result; bit WIDTH is final carry-out
- busy  output  1  high whenever state is not IDLE
- adder_a  output  4  to adder A
- adder_b  output  4  to adder B
- adder_cin  output  1  to adder Cin
- adder_sum  input  5  from adder Sum; bit 4 is nibble carry-out

## Operation
- The FSM has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_a, in_b and in_cin (carry_reg). Set idx=0, go to RUN.
  - RUN: drive adder_a=a_reg[4*idx+:4], adder_b=b_reg[4*idx+:4], adder_cin=carry_reg. Each clock, write adder_sum[3:0] into sum_reg[4*idx+:4], set carry_reg<=adder_sum[4], then idx++. When idx==NIB-1, also write sum_reg[WIDTH]<=adder_sum[4] and go to DONE.
  - DONE: out_valid=1 and out_sum=sum_reg, both held stable. When out_ready is high, go to IDLE.
- in_ready is high only in IDLE and is forced to 0 while rst is high. Operands are not accepted in DONE, even if out_ready is high in the same cycle.
- Operand inputs are sampled only at acceptance. Changes on in_a, in_b or in_cin during RUN or DONE have no effect.
- Outside RUN, adder_a=0, adder_b=0 and adder_cin=0.
- Arithmetic is unsigned and exact: out_sum = in_a + in_b + in_cin, in WIDTH+1 bits. It never wraps.
- The adder is treated as purely combinational. adder_sum is sampled in the same cycle its inputs are driven.
- out_sum holds the last result after DONE until the next result overwrites it.
- Reset, asynchronous and possible at any time, including mid-RUN: state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, sum_reg=0. Any in-flight operation is discarded and no out_valid is produced for it.
- Reset values of outputs: in_ready=0 while rst is high, 1 after release. out_valid=0, out_sum=0, busy=0, adder_a=0, adder_b=0, adder_cin=0.

## Timing
- Accept edge T0, where in_valid&&in_ready is sampled. RUN occupies cycles T0+1 through T0+NIB.
- out_valid rises after edge T0+NIB, i.e. NIB cycles after acceptance.
- With out_ready held high, DONE lasts 1 cycle, IDLE follows, and the next accept can occur at T0+NIB+2. Minimum period is NIB+2 cycles per operation.
- Backpressure: with out_ready low, DONE holds indefinitely. out_valid and out_sum stay stable, and in_ready stays 0.
- NIB=1 (WIDTH=4): exactly one RUN cycle, and the carry-out goes straight to out_sum[4].

## Test plan
- WIDTH=16, in_a=0x0000, in_b=0x0000, in_cin=1 -> out_sum=0x00001; out_valid rises exactly 4 cycles after accept; adder_cin=1 only in the first RUN cycle.
- WIDTH=16, in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x10000. The carry propagates through all 4 nibble steps: adder_cin sequence is 0,1,1,1.
- WIDTH=16, in_a=0xFFFF, in_b=0xFFFF, in_cin=1 -> out_sum=0x1FFFF. Then in_a=0x1234, in_b=0x4321, in_cin=0 -> out_sum=0x05555; the previous carry does not leak into the new operation.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while in_valid=1 with new operands -> out_valid=1, out_sum stable, in_ready=0 throughout. Release out_ready -> one cycle in IDLE, then the new operands are accepted.
- Reset mid-operation: assert rst during the 2nd RUN cycle -> immediately in_ready=0, busy=0, out_valid=0, out_sum=0, adder_* all 0. After release, in_ready=1 and the next add of 0x000A+0x0003 gives 0x0000D.
- WIDTH=4: in_a=0xF, in_b=0xF, in_cin=0 -> out_sum=0x1E, with out_valid 1 cycle after accept.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide unsigned add by sequencing one external 4-bit adder slice LSB nibble first.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_cin,
  input  logic [4:0]       adder_sum
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic carry_reg, last;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH:0] sum_reg;
  assign last = idx == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  end
  assign in_ready  = state == IDLE && !rst;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign out_sum   = sum_reg;
  // The slice is combinational: its sum is captured in the same cycle its operands are driven.
  assign adder_a   = state == RUN ? a_reg[4*idx +: 4] : '0;
  assign adder_b   = state == RUN ? b_reg[4*idx +: 4] : '0;
  assign adder_cin = state == RUN ? carry_reg : 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else if (state == IDLE && in_valid) begin
      idx       <= '0;
      carry_reg <= in_cin;
      a_reg     <= in_a;
      b_reg     <= in_b;
    end else if (state == RUN) begin
      sum_reg[4*idx +: 4] <= adder_sum[3:0];
      carry_reg <= adder_sum[4];
      idx       <= last ? '0 : idx + 1'b1;
      if (last) sum_reg[WIDTH] <= adder_sum[4];
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench for 16-bit and 4-bit sequencer instances.
module tb_nibble_serial_adder_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic in_valid = 0, in_cin = 0, out_ready = 1;
  logic [15:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, busy, adder_cin;
  logic [16:0] out_sum;
  logic [3:0] adder_a, adder_b;
  logic [4:0] adder_sum;
  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_cin};

  logic in_valid4 = 0, in_cin4 = 0, out_ready4 = 1;
  logic [3:0] in_a4 = 0, in_b4 = 0;
  logic in_ready4, out_valid4, busy4, adder_cin4;
  logic [4:0] out_sum4;
  logic [3:0] adder_a4, adder_b4;
  logic [4:0] adder_sum4;
  assign adder_sum4 = {1'b0, adder_a4} + {1'b0, adder_b4} + {4'b0, adder_cin4};

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin), .adder_sum(adder_sum));

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .in_cin(in_cin4), .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .busy(busy4),
    .adder_a(adder_a4), .adder_b(adder_b4), .adder_cin(adder_cin4), .adder_sum(adder_sum4));

  int checks = 0, errors = 0;
  logic [16:0] sb[$];
  logic [4:0] sb4[$];

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, output int n);
    n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; in_valid = 1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready); end
    sb.push_back({1'b0, a} + {1'b0, b} + 17'(c));
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic get_result(input int exp_lat, input logic [3:0] exp_cseq, input logic chk_cseq);
    int k = 0;
    logic [3:0] cseq = '0;
    logic [16:0] e;
    do begin
      @(negedge clk); k++;
      if (busy && !out_valid) cseq = {cseq[2:0], adder_cin};
    end while (!out_valid && k < 50);
    checks++;
    if (k - 1 != exp_lat) begin errors++; $display("FAIL latency: got %0d required %0d", k - 1, exp_lat); end
    e = sb.size() > 0 ? sb.pop_front() : 'x;
    checks++;
    if (out_sum !== e) begin errors++; $display("FAIL out_sum: got %h required %h", out_sum, e); end
    if (chk_cseq) begin
      checks++;
      if (cseq !== exp_cseq) begin errors++; $display("FAIL cin_seq: got %b required %b", cseq, exp_cseq); end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_sum, adder_a, adder_b, adder_cin} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b sum=%h a=%h b=%h cin=%b required all 0",
               in_ready, out_valid, busy, out_sum, adder_a, adder_b, adder_cin);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic;
    int n;
    send(16'h0000, 16'h0000, 1'b1, n);
    get_result(4, 4'b1000, 1'b1);
  endtask

  task automatic test_carry;
    int n;
    send(16'hFFFF, 16'h0001, 1'b0, n);
    get_result(4, 4'b0111, 1'b1);
  endtask

  task automatic test_back_to_back;
    int n;
    send(16'hFFFF, 16'hFFFF, 1'b1, n);
    get_result(4, 4'b1111, 1'b1);
    send(16'h1234, 16'h4321, 1'b0, n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL b2b_period: extra wait %0d required 0", n); end
    get_result(4, 4'b0000, 1'b1);
  endtask

  task automatic test_hold;
    logic [16:0] held;
    held = out_sum;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== held || out_sum !== 17'h05555) begin
      errors++; $display("FAIL hold_idle: vld=%b sum=%h required 0 / %h", out_valid, out_sum, 17'h05555);
    end
  endtask

  task automatic test_backpressure;
    int n, k;
    out_ready = 0;
    send(16'h00F0, 16'h0F10, 1'b0, n);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 50);
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== sb[0]) begin
        errors++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b sum=%h required 1/0/%h", i, out_valid, in_ready, out_sum, sb[0]);
      end
      @(negedge clk);
    end
    void'(sb.pop_front());
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
    sb.push_back(17'h03334);
    @(posedge clk);
    #1 in_valid = 0;
    get_result(4, 4'b1000, 1'b1);
  endtask

  task automatic test_reset_mid;
    int n;
    send(16'h5555, 16'h5555, 1'b0, n);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_sum, adder_a, adder_b, adder_cin} !== '0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b busy=%b sum=%h a=%h b=%h cin=%b required all 0",
               in_ready, out_valid, busy, out_sum, adder_a, adder_b, adder_cin);
    end
    sb.delete();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_release: rdy=%b required 1", in_ready); end
    send(16'h000A, 16'h0003, 1'b0, n);
    get_result(4, 4'b0000, 1'b1);
  endtask

  task automatic test_width4;
    int k = 0;
    logic [4:0] e;
    @(negedge clk);
    in_a4 = 4'hF; in_b4 = 4'hF; in_cin4 = 0; in_valid4 = 1;
    checks++;
    if (in_ready4 !== 1'b1) begin errors++; $display("FAIL w4_ready: got %b required 1", in_ready4); end
    sb4.push_back({1'b0, in_a4} + {1'b0, in_b4} + {4'b0, in_cin4});
    @(posedge clk);
    #1 in_valid4 = 0;
    do begin @(negedge clk); k++; end while (!out_valid4 && k < 50);
    checks++;
    if (k - 1 != 1) begin errors++; $display("FAIL w4_latency: got %0d required 1", k - 1); end
    e = sb4.size() > 0 ? sb4.pop_front() : 'x;
    checks++;
    if (out_sum4 !== e || out_sum4 !== 5'h1E) begin
      errors++; $display("FAIL w4_sum: got %h required %h", out_sum4, 5'h1E);
    end
  endtask

  task automatic test_random;
    int n;
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), n);
      get_result(4, 4'b0000, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_back_to_back;
    test_hold;
    test_backpressure;
    test_reset_mid;
    test_width4;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
